// File: rtl/rs232_stim_gen_if.sv
// Control and serial-output bundle of the RS-232 stimulus generator.
interface rs232_stim_gen_if;
  logic       TRG;
  logic       MODE;
  logic       FREE_RUN;
  logic [7:0] DATA_IN;
  logic       TXD;
  logic       BUSY;
  logic       DONE;
  logic [7:0] BYTE_OUT;

  modport master (
    output TRG, MODE, FREE_RUN, DATA_IN,
    input  TXD, BUSY, DONE, BYTE_OUT
  );

  modport slave (
    input  TRG, MODE, FREE_RUN, DATA_IN,
    output TXD, BUSY, DONE, BYTE_OUT
  );
endinterface

// File: rtl/rs232_stim_gen.sv
// RS-232 frame generator: sends a fixed or LFSR-random payload as one UART frame
// per trigger, or back-to-back frames while FREE_RUN is high.
module rs232_stim_gen #(
  parameter int unsigned CLK_DIV   = 100,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic           CLK_50MHZ,
  input  logic           RST,
  rs232_stim_gen_if.slave bus
);

  localparam int unsigned BAUD_W = 16;
  localparam int unsigned BIT_W  = 3;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLK_DIV - 2);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [7:0]        DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic              HAS_PAR   = (PARITY != 0);
  localparam logic              ODD_PAR   = (PARITY == 2);
  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0]       LFSR_POLY = 16'hB400;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic              txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        byte_q, byte_d;

  logic [15:0]       lfsr_step;
  logic [7:0]        payload;
  logic              bit_end;

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      lfsr_q  <= lfsr_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      byte_q  <= byte_d;
    end
  end

  // Next-state and registered-output logic; TXD changes on the bit boundary edge
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    lfsr_d  = lfsr_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    byte_d  = byte_q;

    lfsr_step = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_POLY : 16'h0000);
    payload   = (bus.MODE ? lfsr_step[7:0] : bus.DATA_IN) & DATA_MASK;
    bit_end   = (baud_q == BAUD_LAST);

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (bus.TRG || bus.FREE_RUN) begin
          state_d = START;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          shift_d = payload;
          par_d   = (^payload) ^ ODD_PAR;
          byte_d  = payload;
          if (bus.MODE) lfsr_d = lfsr_step;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = PAR;
              txd_d   = par_q;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end
      STOP: begin
        // DONE is registered, so raise it one cycle early to cover the final cycle
        if (bit_q == STOP_LAST && baud_q == BAUD_PRE) done_d = 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        bit_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.TXD      = txd_q;
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.BYTE_OUT = byte_q;

endmodule

// File: tb/tb_rs232_stim_gen.sv
// Directed bench for rs232_stim_gen: four parameterisations share one clock and reset.
module tb_rs232_stim_gen;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst;
  logic       trg  [4];
  logic       mode [4];
  logic       fr   [4];
  logic [7:0] din  [4];
  logic       txd  [4];
  logic       busy [4];
  logic       done [4];
  logic [7:0] bout [4];

  int checks = 0;
  int errors = 0;

  rs232_stim_gen_if b0 ();
  rs232_stim_gen_if b1 ();
  rs232_stim_gen_if b2 ();
  rs232_stim_gen_if b3 ();

  assign b0.TRG = trg[0]; assign b0.MODE = mode[0]; assign b0.FREE_RUN = fr[0]; assign b0.DATA_IN = din[0];
  assign b1.TRG = trg[1]; assign b1.MODE = mode[1]; assign b1.FREE_RUN = fr[1]; assign b1.DATA_IN = din[1];
  assign b2.TRG = trg[2]; assign b2.MODE = mode[2]; assign b2.FREE_RUN = fr[2]; assign b2.DATA_IN = din[2];
  assign b3.TRG = trg[3]; assign b3.MODE = mode[3]; assign b3.FREE_RUN = fr[3]; assign b3.DATA_IN = din[3];
  assign txd[0] = b0.TXD; assign busy[0] = b0.BUSY; assign done[0] = b0.DONE; assign bout[0] = b0.BYTE_OUT;
  assign txd[1] = b1.TXD; assign busy[1] = b1.BUSY; assign done[1] = b1.DONE; assign bout[1] = b1.BYTE_OUT;
  assign txd[2] = b2.TXD; assign busy[2] = b2.BUSY; assign done[2] = b2.DONE; assign bout[2] = b2.BYTE_OUT;
  assign txd[3] = b3.TXD; assign busy[3] = b3.BUSY; assign done[3] = b3.DONE; assign bout[3] = b3.BYTE_OUT;

  rs232_stim_gen u0 (.CLK_50MHZ(clk), .RST(rst), .bus(b0));
  rs232_stim_gen #(.CLK_DIV(8), .PARITY(1)) u1 (.CLK_50MHZ(clk), .RST(rst), .bus(b1));
  rs232_stim_gen #(.CLK_DIV(8), .PARITY(2), .DATA_BITS(7)) u2 (.CLK_50MHZ(clk), .RST(rst), .bus(b2));
  rs232_stim_gen #(.CLK_DIV(4), .STOP_BITS(2)) u3 (.CLK_50MHZ(clk), .RST(rst), .bus(b3));

  typedef struct {
    int          dut;
    logic [7:0]  data;
    logic [7:0]  exp_byte;
    logic [15:0] exp_bits;  // line level per bit slot, start bit in [0]
    int          nbits;
    int          cd;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Trigger one MODE=0 frame from idle and check every cycle of it plus the idle cycle after.
  task automatic run_frame(input vec_t v);
    int bad_txd  = 0;
    int bad_done = 0;
    int bad_busy = 0;
    int flen     = v.nbits * v.cd;
    trg[v.dut]  = 1'b1;
    mode[v.dut] = 1'b0;
    din[v.dut]  = v.data;
    step();
    trg[v.dut] = 1'b0;
    chk("byte_out", 32'(bout[v.dut]), 32'(v.exp_byte));
    for (int c = 1; c <= flen; c++) begin
      if (txd[v.dut] !== v.exp_bits[(c - 1) / v.cd]) bad_txd++;
      if (done[v.dut] !== (c == flen)) bad_done++;
      if (busy[v.dut] !== 1'b1) bad_busy++;
      if (c < flen) step();
    end
    step();
    chk("frame_txd_bad_cycles", 32'(bad_txd), 32'd0);
    chk("frame_done_bad_cycles", 32'(bad_done), 32'd0);
    chk("frame_busy_bad_cycles", 32'(bad_busy), 32'd0);
    chk("after_frame_busy", 32'(busy[v.dut]), 32'd0);
    chk("after_frame_txd", 32'(txd[v.dut]), 32'd1);
  endtask

  initial begin
    int done_cnt;
    int done_cyc;
    int busy_cnt;
    int n;
    int starts [3];
    logic [7:0] bytes [3];
    logic prev;

    vecs[0] = '{0, 8'h55, 8'h55, 16'h02AA, 10, 100};
    vecs[1] = '{0, 8'hA3, 8'hA3, 16'h0346, 10, 100};
    vecs[2] = '{1, 8'h55, 8'h55, 16'h04AA, 11, 8};
    vecs[3] = '{1, 8'h07, 8'h07, 16'h060E, 11, 8};
    vecs[4] = '{2, 8'h87, 8'h07, 16'h020E, 10, 8};
    vecs[5] = '{2, 8'h00, 8'h00, 16'h0300, 10, 8};

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      trg[i] = 1'b0; mode[i] = 1'b0; fr[i] = 1'b0; din[i] = 8'h00;
    end
    repeat (3) step();
    chk("reset_txd", 32'(txd[0]), 32'd1);
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_done", 32'(done[0]), 32'd0);
    chk("reset_byte_out", 32'(bout[0]), 32'd0);
    chk("reset_txd_u3", 32'(txd[3]), 32'd1);

    // Frame starts on the first edge after reset release; first LFSR value is 0x70
    rst = 1'b0; trg[0] = 1'b1; mode[0] = 1'b1;
    step();
    trg[0] = 1'b0;
    chk("post_reset_start_busy", 32'(busy[0]), 32'd1);
    chk("post_reset_start_txd", 32'(txd[0]), 32'd0);
    chk("post_reset_lfsr_byte", 32'(bout[0]), 32'h70);

    // Reset in cycle 350 of the frame aborts it
    repeat (349) step();
    chk("mid_frame_busy_c350", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_txd", 32'(txd[0]), 32'd1);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_byte_out", 32'(bout[0]), 32'd0);
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 1100; c++) begin
      step();
      if (done[0] === 1'b1) done_cnt++;
      if (busy[0] !== 1'b0 || txd[0] !== 1'b1) busy_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_stays_idle", 32'(busy_cnt), 32'd0);

    // New random frame repeats the first LFSR value; mid-frame TRG/MODE/DATA_IN are ignored
    trg[0] = 1'b1; mode[0] = 1'b1; din[0] = 8'h11;
    step();
    trg[0] = 1'b0;
    chk("reseed_lfsr_byte", 32'(bout[0]), 32'h70);
    done_cnt = 0; done_cyc = 0; busy_cnt = 0;
    for (int c = 1; c <= 1200; c++) begin
      if (done[0] === 1'b1) begin done_cnt++; done_cyc = c; end
      if (busy[0] === 1'b1) busy_cnt++;
      if (c == 1001) chk("busy_low_at_1001", 32'(busy[0]), 32'd0);
      if (c == 500) begin trg[0] = 1'b1; mode[0] = 1'b0; din[0] = 8'hFF; end
      if (c == 501) trg[0] = 1'b0;
      step();
    end
    chk("retrigger_done_count", 32'(done_cnt), 32'd1);
    chk("retrigger_done_cycle", 32'(done_cyc), 32'd1000);
    chk("retrigger_busy_cycles", 32'(busy_cnt), 32'd1000);
    chk("retrigger_byte_kept", 32'(bout[0]), 32'h70);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // Free-running random frames on the 2-stop-bit, CLK_DIV=4 instance
    mode[3] = 1'b1; fr[3] = 1'b1;
    n = 0; done_cnt = 0; busy_cnt = 0; prev = busy[3];
    for (int i = 0; i < 3; i++) begin starts[i] = 0; bytes[i] = 8'h00; end
    for (int c = 1; c <= 400; c++) begin
      step();
      if (busy[3] === 1'b1 && prev !== 1'b1) begin
        if (n < 3) begin starts[n] = c; bytes[n] = bout[3]; end
        n++;
        if (n == 3) fr[3] = 1'b0;
      end
      if (busy[3] === 1'b1) busy_cnt++;
      if (done[3] === 1'b1) done_cnt++;
      prev = busy[3];
    end
    chk("freerun_frame_count", 32'(n), 32'd3);
    chk("freerun_spacing_1", 32'(starts[1] - starts[0]), 32'd45);
    chk("freerun_spacing_2", 32'(starts[2] - starts[1]), 32'd45);
    chk("freerun_byte_0", 32'(bytes[0]), 32'h70);
    chk("freerun_byte_1", 32'(bytes[1]), 32'h38);
    chk("freerun_byte_2", 32'(bytes[2]), 32'h9C);
    chk("freerun_busy_cycles", 32'(busy_cnt), 32'd132);
    chk("freerun_done_count", 32'(done_cnt), 32'd3);
    chk("freerun_final_txd", 32'(txd[3]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_stim_gen.md
RS232_STIM_GEN -- requirements
Module: rs232_stim_gen

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100: clocks per serial bit; legal range 2..65535.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 The block SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 The block SHALL have parameter STOP_BITS, default 1: stop bits per frame, 1 or 2.
REQ-005 The block SHALL have parameter LFSR_SEED, default 16'hACE1: LFSR reset value; must be nonzero.
REQ-006 The block SHALL have port CLK_50MHZ  in  1  the single clock; all logic on its rising edge.
REQ-007 The block SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-008 The block SHALL have port TRG  in  1  start request; sampled every cycle.
REQ-009 The block SHALL have port MODE  in  1  payload source: 0 = DATA_IN, 1 = LFSR random.
REQ-010 The block SHALL have port FREE_RUN  in  1  high = back-to-back frames without TRG.
REQ-011 The block SHALL have port DATA_IN  in  8  payload for MODE=0; bits above DATA_BITS-1 ignored.
REQ-012 The block SHALL have port TXD  out  1  serial line; idle high, LSB first.
REQ-013 The block SHALL have port BUSY  out  1  frame in progress.
REQ-014 The block SHALL have port DONE  out  1  one-cycle pulse at frame end.
REQ-015 The block SHALL have port BYTE_OUT  out  8  payload of the current/last frame, zero-extended above DATA_BITS.

Function
REQ-016 The block SHALL implement FSM states IDLE, START, DATA, PAR, STOP.
REQ-017 In IDLE with (TRG or FREE_RUN) high, the block SHALL enter START on the next edge and SHALL drive TXD=0 and BUSY=1 from that edge.
REQ-018 The payload SHALL be latched on the IDLE->START edge: DATA_IN[DATA_BITS-1:0] when MODE=0, else the LFSR low DATA_BITS bits after one advance; BYTE_OUT SHALL update on the same edge.
REQ-019 Each bit (start, data, parity, stop) SHALL be held on TXD for exactly CLK_DIV cycles, counted by a baud counter reloaded at every bit boundary.
REQ-020 Data bits SHALL be sent LSB first, DATA_BITS of them; then PAR if PARITY!=0; then STOP_BITS stop bits (TXD=1).
REQ-021 The parity bit SHALL be the XOR of the payload bits for even and its inverse for odd.
REQ-022 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLK_DIV cycles from the START edge.
REQ-023 DONE SHALL pulse high for the final cycle of the last stop bit; on the next edge the FSM SHALL go to IDLE and BUSY SHALL fall.
REQ-024 With FREE_RUN high at DONE, the block SHALL spend exactly one cycle in IDLE (TXD=1, BUSY=0) and then start the next frame.
REQ-025 TRG asserted while BUSY=1 SHALL be ignored and not queued.
REQ-026 The LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing only once per frame start with MODE=1.
REQ-027 MODE, DATA_IN and FREE_RUN changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-028 RST high at a rising edge SHALL force IDLE, TXD=1, BUSY=0, DONE=0, BYTE_OUT=0, counters=0, LFSR=LFSR_SEED, taking priority over all other inputs including mid-frame.
REQ-029 The first frame SHALL be able to start on the cycle after RST falls if TRG is high.

Verification
REQ-030 Defaults, MODE=0, DATA_IN=8'h55, TRG pulse 1 cycle -> TXD = 0,1,0,1,0,1,0,1,0,1, each 100 cycles; DONE at cycle 1000 after START; BUSY low at 1001; BYTE_OUT=8'h55.
REQ-031 PARITY=1, DATA_IN=8'h55 -> parity bit 0; PARITY=2, DATA_BITS=7, DATA_IN=8'h87 -> payload 7'h07, BYTE_OUT=8'h07, parity bit 0, frame 10*CLK_DIV cycles.
REQ-032 STOP_BITS=2, CLK_DIV=4, MODE=1, FREE_RUN=1 for 3 frames -> consecutive frames start 45 cycles apart (44 frame + 1 idle); BYTE_OUT matches reference LFSR sequence from 16'hACE1.
REQ-033 TRG re-asserted at cycle 500 of a frame -> no extra frame; exactly one DONE pulse.
REQ-034 RST at cycle 350 of a frame -> TXD=1, BUSY=0 on next edge; no DONE; next MODE=1 frame repeats first post-seed LFSR value.
